// File: rtl/seq_det_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : seq_det_pkg
//  Purpose  : Shared constants and helpers for the programmable sequence
//             detector.
//  Contents : SEQ_1011   - classic "1011" pattern, right-aligned in 8 bits
//             calc_len_w - width needed to hold a length of 0..max_len
//  Revision : 1.0 - initial release
// ============================================================================
package seq_det_pkg;

  // Right-aligned "1011": bit [3] is the first bit received.
  localparam logic [7:0] SEQ_1011 = 8'h0B;

  // Width of a field able to represent every length from 0 to max_len.
  function automatic int calc_len_w(input int max_len);
    return $clog2(max_len + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
//  Module   : sat_counter
//  Purpose  : Up-counter that sticks at its all-ones value.
//  Ports    : clk   - clock, rising edge
//             reset - asynchronous, active-high reset (count -> 0)
//             clr   - synchronous clear, wins over inc
//             inc   - count one event this cycle
//             cnt   - current count (W bits)
//  Revision : 1.0 - initial release
// ============================================================================
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (inc && (r_cnt != {W{1'b1}})) begin
      r_cnt <= r_cnt + W'(1);
    end
  end

  assign cnt = r_cnt;

endmodule
`default_nettype wire

// File: rtl/seq_detector_prog.sv
`default_nettype none
// ============================================================================
//  Module   : seq_detector_prog
//  Purpose  : Runtime-programmable serial bit-sequence detector with
//             overlapping / non-overlapping modes, a Mealy match output,
//             a registered match output and a saturating match counter.
//  Ports    : clk         - clock, rising edge
//             reset       - asynchronous, active-high reset
//             en          - din valid this cycle
//             din         - serial input bit
//             cfg_load    - latch cfg_pattern/cfg_len/cfg_overlap
//             cfg_pattern - pattern, right-aligned, bit [len-1] first
//             cfg_len     - pattern length (0 = never match)
//             cfg_overlap - 1 = overlapping, 0 = non-overlapping
//             cnt_clr     - synchronous clear of match_count
//             dout        - same-cycle match
//             dout_q      - dout delayed by one cycle
//             match_count - saturating count of matches
//  Revision : 1.0 - initial release
// ============================================================================
module seq_detector_prog
  import seq_det_pkg::*;
#(
  parameter int                 MAX_LEN     = 8,
  parameter int                 LEN_W       = calc_len_w(MAX_LEN),
  parameter int                 CNT_W       = 8,
  parameter logic [MAX_LEN-1:0] RST_PATTERN = MAX_LEN'(SEQ_1011),
  parameter int                 RST_LEN     = 4,
  parameter bit                 RST_OVERLAP = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic               din,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic               cnt_clr,
  output logic               dout,
  output logic               dout_q,
  output logic [CNT_W-1:0]   match_count
);

  localparam int               c_hist_w   = MAX_LEN - 1;
  localparam logic [LEN_W-1:0] c_max_len  = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0] c_fill_max = LEN_W'(MAX_LEN - 1);

  // Configuration registers
  logic [MAX_LEN-1:0]  r_pat;
  logic [LEN_W-1:0]    r_len;
  logic                r_ovl;

  // History of received bits (bit 0 newest) and count of valid history bits
  logic [c_hist_w-1:0] r_hist;
  logic [LEN_W-1:0]    r_fill;
  logic                r_dout_q;

  logic [LEN_W-1:0]    w_eff_len;
  logic [MAX_LEN-1:0]  w_window;
  logic [MAX_LEN-1:0]  w_mask;
  logic [LEN_W:0]      w_fill_p1;
  logic                w_fill_ok;
  logic                w_pat_ok;
  logic                w_len_nz;
  logic                w_match;

  // Lengths beyond MAX_LEN behave as MAX_LEN.
  assign w_eff_len = (r_len > c_max_len) ? c_max_len : r_len;

  // Candidate window: stored history with the current bit appended as LSB.
  assign w_window  = {r_hist, din};

  // Only the low w_eff_len bits of the window take part in the compare.
  for (genvar gi = 0; gi < MAX_LEN; gi++) begin : g_mask
    assign w_mask[gi] = (LEN_W'(gi) < w_eff_len);
  end

  // fill >= L-1 rewritten as fill+1 >= L so L==0 needs no special underflow case.
  assign w_fill_p1 = {1'b0, r_fill} + {{LEN_W{1'b0}}, 1'b1};
  assign w_fill_ok = (w_fill_p1 >= {1'b0, w_eff_len});
  assign w_pat_ok  = (((w_window ^ r_pat) & w_mask) == '0);
  assign w_len_nz  = (w_eff_len != '0);

  // cfg_* can reach dout only through this cfg_load gate.
  assign w_match = en & ~cfg_load & ~reset & w_len_nz & w_fill_ok & w_pat_ok;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pat    <= RST_PATTERN;
      r_len    <= LEN_W'(RST_LEN);
      r_ovl    <= RST_OVERLAP;
      r_hist   <= '0;
      r_fill   <= '0;
      r_dout_q <= 1'b0;
    end else begin
      r_dout_q <= w_match;
      if (cfg_load) begin
        // New configuration starts from an empty history.
        r_pat  <= cfg_pattern;
        r_len  <= cfg_len;
        r_ovl  <= cfg_overlap;
        r_fill <= '0;
      end else if (en) begin
        r_hist <= w_window[c_hist_w-1:0];
        if (w_match && !r_ovl) begin
          r_fill <= '0;
        end else if (r_fill != c_fill_max) begin
          r_fill <= r_fill + LEN_W'(1);
        end
      end
    end
  end

  sat_counter #(
    .W (CNT_W)
  ) u_match_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (cnt_clr),
    .inc   (w_match),
    .cnt   (match_count)
  );

  assign dout   = w_match;
  assign dout_q = r_dout_q;

endmodule
`default_nettype wire

// File: doc/seq_detector_prog.md
Name: seq_detector_prog

Overview:
- Runtime-programmable serial bit-sequence detector. Successor to the fixed 4-bit Mealy detectors in the SEQUENTIAL/SEQUENCE DETECTORS family.
- Pattern is 1..MAX_LEN bits, loadable at runtime. Overlapping or non-overlapping detection is selectable.
- Provides a Mealy (same-cycle) match output, a registered (Moore-timed) match output and a saturating match counter.
- Reset configuration reproduces the classic overlapping "1011" Mealy detector.

Parameters:
- MAX_LEN, 8, maximum pattern length in bits (>=2).
- LEN_W, $clog2(MAX_LEN+1), width of the pattern-length fields.
- CNT_W, 8, match counter width.
- RST_PATTERN, 8'b0000_1011, pattern loaded at reset (right-aligned, MAX_LEN bits).
- RST_LEN, 4, pattern length loaded at reset.
- RST_OVERLAP, 1, overlap mode loaded at reset.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- en  in  1  din valid this cycle; when low, no state changes and no match.
- din  in  1  serial input bit.
- cfg_load  in  1  latch cfg_pattern/cfg_len/cfg_overlap this cycle.
- cfg_pattern  in  MAX_LEN  new pattern, right-aligned; bit [len-1] is the first bit received.
- cfg_len  in  LEN_W  new pattern length.
- cfg_overlap  in  1  1 = overlapping detection, 0 = non-overlapping.
- cnt_clr  in  1  synchronous clear of match_count.
- dout  out  1  Mealy match, combinational from state and din.
- dout_q  out  1  dout registered, one cycle later.
- match_count  out  CNT_W  saturating count of matches.

Behaviour:
- Reset (async) sets:
  - pat <= RST_PATTERN, len <= RST_LEN, ovl <= RST_OVERLAP;
  - hist <= 0, fill <= 0, dout_q <= 0, match_count <= 0.
  - dout = 0 while reset is asserted.
- State:
  - hist[MAX_LEN-2:0] holds the most recent received bits; hist[0] is the newest.
  - fill counts valid history bits and saturates at MAX_LEN-1.
- Effective length: L = min(len, MAX_LEN). If len == 0, the detector never matches; hist and fill still update.
- Match condition, evaluated every cycle: match = en & !cfg_load & (L>=1) & (fill >= L-1) & ({hist[L-2:0], din} == pat[L-1:0]). When L==1, compare din == pat[0] only.
- dout = match. This is combinational: zero-cycle latency from din.
- On a clock edge with en=1 and cfg_load=0:
  - hist shifts left, inserting din at hist[0].
  - If match and ovl==0, fill <= 0 (history is discarded, so no overlap is possible).
  - Otherwise fill <= min(fill+1, MAX_LEN-1).
- en=0: hist, fill and the counter hold; dout=0; dout_q <= 0.
- cfg_load=1:
  - pat/len/ovl are updated at the edge; fill <= 0.
  - din is ignored that cycle; dout=0.
  - The new config takes effect from the next cycle. The first match is possible only after L fresh bits.
- dout_q <= match every cycle, giving a 1-cycle latency.
- match_count:
  - cnt_clr has priority: count <= 0, and a same-cycle match is not counted.
  - Otherwise, on a match, count increments, saturating at 2^CNT_W-1.
- Reset mid-stream drops all partial progress immediately and restores the reset config. A sequence straddling the reset is never detected.
- No combinational path from cfg_* to dout other than through the cfg_load gating term.

Decomposition:
- Package seq_det_pkg holds:
  - localparam function clog2-based LEN_W helper;
  - default pattern constant SEQ_1011 = 8'h0B.
- One natural sub-module: sat_counter (parameter W; inputs clr, inc; output cnt, saturating). Used for match_count.
- The history/compare/fill logic stays in the top level.

Test Plan:
- Reset defaults: din stream 1,0,1,1,0,1,1 with en=1 -> dout high on bits 4 and 7 (overlap); dout_q high one cycle later each; match_count=2.
- Non-overlap: cfg_load pattern 8'h0B, len 4, overlap 0, then stream 1,0,1,1,0,1,1,0,1,1 -> dout high only on bits 4 and 10 (not 7); match_count=2.
- Length extremes:
  - len=1, pattern 1: dout mirrors din (stream 1,1,0 -> 1,1,0).
  - len=MAX_LEN=8, pattern 8'hA5: match only after the full 10100101 sequence.
  - len=0: never matches.
- en gating: stream 1,0,1 with en=1, then en=0 for 3 cycles (din toggling), then 1 with en=1 -> exactly one match. dout stays 0 while en=0.
- Config mid-stream: after 1,0,1, cfg_load with pattern 3'b110 (len 3) while din=1 -> no match that cycle. Stream 1,1,0 -> match on the third bit. The old partial "101" history is not used.
- Counter and reset:
  - With CNT_W=2: 5 matches -> match_count saturates at 3.
  - cnt_clr coincident with a match -> 0.
  - Async reset asserted after 1,0,1, then released, then 1 -> no match; count 0; config back to 1011 overlap.
